stoch_matvec_prod: RTL and testbench
====================================

Name: stoch_matvec_prod

Overview:
- Computes NUM_ROWS parallel dot products of signed stochastic bitstream vectors, i.e. a matrix-vector product, one output bitstream pair per row.
- Signed values use split-unipolar encoding: each value is a positive stream plus a negative stream.
- Per row: popcount of products, a positive and a negative residue counter with saturation, enable gating and an optional pipeline register on the popcount.
- Used by stochastic linear-algebra kernels that need signed operands and many rows at once.

Parameters:
- VEC_LEN, 4: elements per row / vector length (>=1).
- NUM_ROWS, 2: number of matrix rows (>=1).
- PIPE, 0: 0 = combinational popcount; 1 = popcount and en registered (+1 cycle latency).
- SAT_MAX, 2*VEC_LEN: counter saturation ceiling (>= VEC_LEN).

Ports:
- CLK  input  1  clock.
- nRST  input  1  synchronous active-low reset.
- en  input  1  accumulate enable.
- a_p  input  NUM_ROWS*VEC_LEN  matrix positive streams; row r, column i at bit r*VEC_LEN+i.
- a_n  input  NUM_ROWS*VEC_LEN  matrix negative streams; same indexing.
- v_p  input  VEC_LEN  vector positive streams.
- v_n  input  VEC_LEN  vector negative streams.
- y_p  output  NUM_ROWS  per-row positive result stream.
- y_n  output  NUM_ROWS  per-row negative result stream.

Behaviour:
- Reset is nRST, synchronous, active-low; clock is CLK. While nRST=0 at a CLK edge, every counter and pipeline register clears to 0.
- Outputs are combinational from registered state and the current or registered sums. With all counters at 0 and zero sums, y_p = y_n = 0.
- Per element products:
  - pp[r][i] = (a_p & v_p) | (a_n & v_n)
  - pn[r][i] = (a_p & v_n) | (a_n & v_p)
- Per row: s_p = popcount(pp[r]) and s_n = popcount(pn[r]). Each is unsigned, width $clog2(VEC_LEN+1).
- Counter width CW = $clog2(SAT_MAX+VEC_LEN+1). cnt_p and cnt_n are unsigned and never negative.
- Positive path, per row, each cycle (with e, s = current values when PIPE=0, or registered copies when PIPE=1):
  - new_p = cnt_p + (e ? s_p : 0)
  - y_p = e & (new_p != 0)
  - next cnt_p = min(new_p - y_p, SAT_MAX)
- Negative path is identical using s_n, cnt_n and y_n. The two paths are independent; y_p and y_n may both be 1 in the same cycle, and no cancellation is performed.
- en=0 (effective e=0): counters hold, outputs 0, popcount ignored.
- Saturation: any excess above SAT_MAX is discarded and no flag is raised. The result is the minimum, applied after the y decrement.
- PIPE=1: stage register holds s_p, s_n and en, and is cleared by reset. The output for inputs presented at cycle t appears at cycle t+1. The first cycle after reset uses zero sums.
- Latency: PIPE=0 gives a combinational input-to-output path; PIPE=1 gives 1 cycle.
- Reset mid-operation discards all residue; the first post-reset output reflects only new inputs (PIPE=0) or zeros (PIPE=1).
- Rows share v_p/v_n only; no state is shared across rows.
- All counters use non-blocking updates on posedge CLK; there are no other clocks.

Test Plan:
(Defaults VEC_LEN=4, NUM_ROWS=2, SAT_MAX=8, PIPE=0 unless stated.)
1. Reset: nRST=0 for 2 cycles with random inputs and en=1 -> y_p=y_n=0 on the cycle after release, given all-zero inputs.
2. Unipolar burst: en=1, row0 a_p=4'hF, v_p=4'hF for 1 cycle, then all inputs 0 -> y_p[0]=1 for exactly 4 consecutive cycles, then 0; y_n and row1 stay 0.
3. Sign: a_p row1=4'b0011, v_n=4'b0001 for 1 cycle -> y_n[1]=1 for 1 cycle; y_p[1] stays 0.
4. Saturation: row0 all-ones on a_p/v_p for 10 cycles, then 0 -> counter follows 3,6,8,8,… ; after release y_p[0] stays high exactly 8 cycles.
5. Enable: load counter to 3, then en=0 for 5 cycles -> y_p=0 and counter holds; en=1 with zero inputs -> exactly 3 high cycles.
6. PIPE=1: repeat scenario 2 -> identical waveform shifted 1 cycle later. Assert nRST mid-burst -> outputs 0 the cycle after reset, and no residual ones afterwards.

Source files
------------

// File: rtl/stoch_matvec_prod.sv
// stoch_matvec_prod: signed stochastic matrix-vector product.
// Each row forms split-unipolar element products against the shared vector,
// popcounts them, and drains a positive and a negative residue counter into
// one output bit per cycle. Counters saturate at SAT_MAX. An optional stage
// register on the popcounts and enable adds one cycle of latency.
module stoch_matvec_prod #(
    parameter int VEC_LEN  = 4,
    parameter int NUM_ROWS = 2,
    parameter int PIPE     = 0,
    parameter int SAT_MAX  = 2 * VEC_LEN
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         en,
    input  logic [NUM_ROWS*VEC_LEN-1:0]  a_p,
    input  logic [NUM_ROWS*VEC_LEN-1:0]  a_n,
    input  logic [VEC_LEN-1:0]           v_p,
    input  logic [VEC_LEN-1:0]           v_n,
    output logic [NUM_ROWS-1:0]          y_p,
    output logic [NUM_ROWS-1:0]          y_n
);

    localparam int SW = $clog2(VEC_LEN + 1);
    localparam int CW = $clog2(SAT_MAX + VEC_LEN + 1);
    localparam logic [CW-1:0] SAT = CW'(SAT_MAX);

    // Effective enable seen by the counters (direct or staged).
    logic e;

    generate
        if (PIPE != 0) begin : g_en_pipe
            logic en_reg;

            // Stage the enable alongside the popcounts.
            always_ff @(posedge CLK) begin
                if (!nRST) en_reg <= 1'b0;
                else       en_reg <= en;
            end

            assign e = en_reg;
        end else begin : g_en_direct
            assign e = en;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
            logic [VEC_LEN-1:0] pp;
            logic [VEC_LEN-1:0] pn;
            logic [SW-1:0]      s_p;
            logic [SW-1:0]      s_n;
            logic [SW-1:0]      s_p_eff;
            logic [SW-1:0]      s_n_eff;
            logic [CW-1:0]      cnt_p_reg;
            logic [CW-1:0]      cnt_n_reg;
            logic [CW-1:0]      cnt_p_next;
            logic [CW-1:0]      cnt_n_next;
            logic [CW-1:0]      new_p;
            logic [CW-1:0]      new_n;
            logic [CW-1:0]      dec_p;
            logic [CW-1:0]      dec_n;
            logic               row_y_p;
            logic               row_y_n;

            // Like signs give a positive product, unlike signs a negative one.
            assign pp = (a_p[gi*VEC_LEN +: VEC_LEN] & v_p) |
                        (a_n[gi*VEC_LEN +: VEC_LEN] & v_n);
            assign pn = (a_p[gi*VEC_LEN +: VEC_LEN] & v_n) |
                        (a_n[gi*VEC_LEN +: VEC_LEN] & v_p);

            // Popcount both product vectors.
            always_comb begin
                s_p = '0;
                s_n = '0;
                for (int i = 0; i < VEC_LEN; i++) begin
                    s_p = s_p + SW'(pp[i]);
                    s_n = s_n + SW'(pn[i]);
                end
            end

            if (PIPE != 0) begin : g_stage
                logic [SW-1:0] s_p_reg;
                logic [SW-1:0] s_n_reg;

                // Stage register for the popcounts; cleared so the first
                // post-reset cycle sees zero sums.
                always_ff @(posedge CLK) begin
                    if (!nRST) begin
                        s_p_reg <= '0;
                        s_n_reg <= '0;
                    end else begin
                        s_p_reg <= s_p;
                        s_n_reg <= s_n;
                    end
                end

                assign s_p_eff = s_p_reg;
                assign s_n_eff = s_n_reg;
            end else begin : g_nostage
                assign s_p_eff = s_p;
                assign s_n_eff = s_n;
            end

            // Accumulate, emit one bit when residue is present, then clamp.
            // The clamp is applied after the output decrement.
            always_comb begin
                new_p   = cnt_p_reg + (e ? CW'(s_p_eff) : '0);
                new_n   = cnt_n_reg + (e ? CW'(s_n_eff) : '0);
                row_y_p = e & (new_p != '0);
                row_y_n = e & (new_n != '0);
                dec_p   = new_p - CW'(row_y_p);
                dec_n   = new_n - CW'(row_y_n);
                cnt_p_next = (dec_p > SAT) ? SAT : dec_p;
                cnt_n_next = (dec_n > SAT) ? SAT : dec_n;
            end

            // Residue counters; reset discards any pending residue.
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    cnt_p_reg <= '0;
                    cnt_n_reg <= '0;
                end else begin
                    cnt_p_reg <= cnt_p_next;
                    cnt_n_reg <= cnt_n_next;
                end
            end

            assign y_p[gi] = row_y_p;
            assign y_n[gi] = row_y_n;
        end
    endgenerate

endmodule

// File: tb/tb_stoch_matvec_prod.sv
// Bench for stoch_matvec_prod: a combinational-popcount instance and a
// staged instance share stimulus and are checked each cycle against a
// residue-counting reference model, plus fixed waveform expectations.
module tb_stoch_matvec_prod;

    localparam int VL  = 4;
    localparam int NR  = 2;
    localparam int SAT = 8;

    logic          CLK;
    logic          nRST;
    logic          en;
    logic [NR*VL-1:0] a_p, a_n;
    logic [VL-1:0] v_p, v_n;
    logic [NR-1:0] y_p0, y_n0, y_p1, y_n1;

    stoch_matvec_prod #(.VEC_LEN(VL), .NUM_ROWS(NR), .PIPE(0), .SAT_MAX(SAT)) u_dut0 (
        .CLK(CLK), .nRST(nRST), .en(en), .a_p(a_p), .a_n(a_n),
        .v_p(v_p), .v_n(v_n), .y_p(y_p0), .y_n(y_n0)
    );

    stoch_matvec_prod #(.VEC_LEN(VL), .NUM_ROWS(NR), .PIPE(1), .SAT_MAX(SAT)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .en(en), .a_p(a_p), .a_n(a_n),
        .v_p(v_p), .v_n(v_n), .y_p(y_p1), .y_n(y_n1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: residues as plain integers.
    int m_cp0[NR], m_cn0[NR];
    int m_cp1[NR], m_cn1[NR];
    int m_sp1[NR], m_sn1[NR];
    bit m_e1;
    logic [NR-1:0] exp_p0, exp_n0, exp_p1, exp_n1;

    // Number of positive (neg=0) or negative (neg=1) products in row r.
    function automatic int psum(int r, bit neg);
        int s = 0;
        for (int i = 0; i < VL; i++) begin
            bit ap = a_p[r*VL+i];
            bit an = a_n[r*VL+i];
            bit vp = v_p[i];
            bit vn = v_n[i];
            if (!neg && ((ap && vp) || (an && vn))) s++;
            if (neg  && ((ap && vn) || (an && vp))) s++;
        end
        return s;
    endfunction

    function automatic int nxt(int c, int s, bit e);
        int n = c + (e ? s : 0);
        if (e && n != 0) n = n - 1;
        return (n > SAT) ? SAT : n;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < NR; r++) begin
            m_cp0[r] = 0; m_cn0[r] = 0; m_cp1[r] = 0; m_cn1[r] = 0;
            m_sp1[r] = 0; m_sn1[r] = 0;
        end
        m_e1 = 1'b0;
    endfunction

    // Wait for the sampling edge and compute expected outputs.
    task automatic settle();
        @(negedge CLK);
        for (int r = 0; r < NR; r++) begin
            exp_p0[r] = en && ((m_cp0[r] + psum(r, 0)) != 0);
            exp_n0[r] = en && ((m_cn0[r] + psum(r, 1)) != 0);
            exp_p1[r] = m_e1 && ((m_cp1[r] + m_sp1[r]) != 0);
            exp_n1[r] = m_e1 && ((m_cn1[r] + m_sn1[r]) != 0);
        end
    endtask

    // Advance the model across the next rising edge.
    task automatic tick();
        int np0[NR], nn0[NR], np1[NR], nn1[NR], sp[NR], sn[NR];
        bit ne;
        for (int r = 0; r < NR; r++) begin
            sp[r]  = psum(r, 0);
            sn[r]  = psum(r, 1);
            np0[r] = nxt(m_cp0[r], sp[r], en);
            nn0[r] = nxt(m_cn0[r], sn[r], en);
            np1[r] = nxt(m_cp1[r], m_sp1[r], m_e1);
            nn1[r] = nxt(m_cn1[r], m_sn1[r], m_e1);
        end
        ne = en;
        @(posedge CLK);
        if (!nRST) begin
            model_clear();
        end else begin
            for (int r = 0; r < NR; r++) begin
                m_cp0[r] = np0[r]; m_cn0[r] = nn0[r];
                m_cp1[r] = np1[r]; m_cn1[r] = nn1[r];
                m_sp1[r] = sp[r];  m_sn1[r] = sn[r];
            end
            m_e1 = ne;
        end
        #1;
    endtask

    task automatic zero_inputs();
        a_p = '0; a_n = '0; v_p = '0; v_n = '0;
    endtask

    task automatic drain(int n);
        zero_inputs();
        en = 1'b1;
        for (int k = 0; k < n; k++) begin
            settle();
            n_checks++;
            if ({y_p0, y_n0, y_p1, y_n1} !== {exp_p0, exp_n0, exp_p1, exp_n1}) begin
                n_fail++;
                $display("FAIL drain_model cyc %0d: got %b want %b", k,
                         {y_p0, y_n0, y_p1, y_n1}, {exp_p0, exp_n0, exp_p1, exp_n1});
            end
            tick();
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        en   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a_p = NR*VL'($urandom); a_n = NR*VL'($urandom);
            v_p = VL'($urandom);    v_n = VL'($urandom);
            settle();
            n_checks++;
            if ({y_p0, y_n0, y_p1, y_n1} !== {exp_p0, exp_n0, exp_p1, exp_n1}) begin
                n_fail++;
                $display("FAIL reset_hold_model cyc %0d: got %b want %b", k,
                         {y_p0, y_n0, y_p1, y_n1}, {exp_p0, exp_n0, exp_p1, exp_n1});
            end
            tick();
        end
        nRST = 1'b1;
        zero_inputs();
        settle();
        n_checks++;
        if ({y_p0, y_n0, y_p1, y_n1} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 0", {y_p0, y_n0, y_p1, y_n1});
        end
        tick();
        $display("test_reset done");
    endtask

    // Row-0 burst of four products, then idle: 4 highs on the direct
    // instance from cycle 0, and on the staged one from cycle 1.
    task automatic test_burst();
        logic [NR-1:0] wp0, wp1;
        drain(12);
        for (int k = 0; k < 8; k++) begin
            zero_inputs();
            if (k == 0) begin
                a_p[VL-1:0] = '1;
                v_p = '1;
            end
            settle();
            wp0 = {1'b0, (k < 4) ? 1'b1 : 1'b0};
            wp1 = {1'b0, (k >= 1 && k < 5) ? 1'b1 : 1'b0};
            n_checks++;
            if ({y_p0, y_n0, y_p1, y_n1} !== {wp0, 2'b00, wp1, 2'b00}) begin
                n_fail++;
                $display("FAIL burst_wave cyc %0d: got %b want %b", k,
                         {y_p0, y_n0, y_p1, y_n1}, {wp0, 2'b00, wp1, 2'b00});
            end
            tick();
        end
        $display("test_burst done");
    endtask

    task automatic test_sign();
        drain(12);
        for (int k = 0; k < 3; k++) begin
            zero_inputs();
            if (k == 0) begin
                a_p[2*VL-1:VL] = 4'b0011;
                v_n = 4'b0001;
            end
            settle();
            n_checks++;
            if ({y_p0, y_n0} !== {2'b00, (k == 0) ? 2'b10 : 2'b00}) begin
                n_fail++;
                $display("FAIL sign_wave cyc %0d: got y_p=%b y_n=%b want y_n[1]=%0d only",
                         k, y_p0, y_n0, (k == 0));
            end
            tick();
        end
        $display("test_sign done");
    endtask

    task automatic test_saturation();
        int highs = 0;
        drain(12);
        for (int k = 0; k < 10; k++) begin
            zero_inputs();
            a_p[VL-1:0] = '1;
            v_p = '1;
            settle();
            n_checks++;
            if ({y_p0, y_n0, y_p1, y_n1} !== {exp_p0, exp_n0, exp_p1, exp_n1}) begin
                n_fail++;
                $display("FAIL sat_load_model cyc %0d: got %b want %b", k,
                         {y_p0, y_n0, y_p1, y_n1}, {exp_p0, exp_n0, exp_p1, exp_n1});
            end
            tick();
        end
        zero_inputs();
        for (int k = 0; k < 12; k++) begin
            settle();
            if (y_p0[0] === 1'b1) highs++;
            tick();
        end
        n_checks++;
        if (highs != SAT) begin
            n_fail++;
            $display("FAIL sat_drain_count: got %0d high cycles want %0d", highs, SAT);
        end
        $display("test_saturation done");
    endtask

    task automatic test_enable();
        int highs = 0;
        drain(12);
        zero_inputs();
        a_p[VL-1:0] = '1;
        v_p = '1;
        settle();
        tick();
        zero_inputs();
        a_p = NR*VL'($urandom); v_p = VL'($urandom);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            n_checks++;
            if (y_p0 !== '0 || y_n0 !== '0) begin
                n_fail++;
                $display("FAIL enable_off cyc %0d: got y_p=%b y_n=%b want 0", k, y_p0, y_n0);
            end
            tick();
        end
        zero_inputs();
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            if (y_p0[0] === 1'b1) highs++;
            tick();
        end
        n_checks++;
        if (highs != 3) begin
            n_fail++;
            $display("FAIL enable_hold_count: got %0d high cycles want 3", highs);
        end
        $display("test_enable done");
    endtask

    task automatic test_reset_mid();
        drain(12);
        for (int k = 0; k < 2; k++) begin
            zero_inputs();
            a_p[VL-1:0] = '1; v_p = '1;
            a_n[2*VL-1:VL] = '1; v_n = '1;
            settle();
            tick();
        end
        zero_inputs();
        nRST = 1'b0;
        settle();
        tick();
        nRST = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            n_checks++;
            if ({y_p0, y_n0, y_p1, y_n1} !== '0) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got %b want 0", k, {y_p0, y_n0, y_p1, y_n1});
            end
            tick();
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            a_p  = NR*VL'($urandom); a_n = NR*VL'($urandom);
            v_p  = VL'($urandom);    v_n = VL'($urandom);
            en   = ($urandom_range(0, 3) != 0);
            nRST = ($urandom_range(0, 39) != 0);
            settle();
            n_checks++;
            if ({y_p0, y_n0, y_p1, y_n1} !== {exp_p0, exp_n0, exp_p1, exp_n1}) begin
                n_fail++;
                $display("FAIL random_model cyc %0d: got %b want %b", k,
                         {y_p0, y_n0, y_p1, y_n1}, {exp_p0, exp_n0, exp_p1, exp_n1});
            end
            tick();
        end
        nRST = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        nRST = 1'b0;
        en   = 1'b0;
        zero_inputs();
        model_clear();
        tick();
        tick();
        test_reset();
        test_burst();
        test_sign();
        test_saturation();
        test_enable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
